// File: rtl/joust_input.sv
// Joust input conditioning: PS/2 key latches merged with two joysticks, plus coin pulse shaping.
// Optional macro JOUST_COIN_SHAPER_EN builds the per-coin pulse/gap FSMs; otherwise coins pass through raw.
module joust_input #(
  parameter int PULSE_CYC = 4800000,
  parameter int GAP_CYC   = 4800000
) (
  input  logic        clk_sys,
  input  logic        I_RESET_N,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  output logic [7:0]  sw,
  output logic [8:0]  ja,
  output logic [8:0]  jb
);

  localparam int K_P1_FLAP  = 0;
  localparam int K_P1_LEFT  = 1;
  localparam int K_P1_RIGHT = 2;
  localparam int K_P2_FLAP  = 3;
  localparam int K_P2_LEFT  = 4;
  localparam int K_P2_RIGHT = 5;
  localparam int K_START1   = 6;
  localparam int K_START2   = 7;
  localparam int K_LCOIN    = 8;
  localparam int K_MCOIN    = 9;
  localparam int K_RCOIN    = 10;
  localparam int K_HSRESET  = 11;
  localparam int K_AUTOUP   = 12;
  localparam int K_ADVANCE  = 13;
  localparam int K_SLAM     = 14;
  localparam int NK         = 15;

  if (PULSE_CYC < 1 || GAP_CYC < 1) begin : g_cfg_check
    $error("joust_input: PULSE_CYC and GAP_CYC must be at least 1");
  end

  logic          tog_q;
  logic          primed_q;
  logic          evt_s;
  logic [NK-1:0] key_q;
  logic [NK-1:0] key_d;
  logic [2:0]    coin_raw_s;
  logic [2:0]    coin_out_s;
  logic [7:0]    sw_d;
  logic [8:0]    ja_d;
  logic [8:0]    jb_d;
  logic [7:0]    sw_q;
  logic [8:0]    ja_q;
  logic [8:0]    jb_q;
  logic          unused_s;

  assign unused_s = ^{joy_0[15:7], joy_0[3:2], joy_1[15:7], joy_1[3:2]};

  // The first clock after reset only captures the toggle, so a stale toggle never decodes.
  assign evt_s = primed_q && (ps2_key[10] != tog_q);

  // Key decode: on an event the matching latch follows the pressed bit.
  always_comb begin
    key_d = key_q;
    if (evt_s) begin
      case ({ps2_key[8], ps2_key[7:0]})
        9'h02B:  key_d[K_P1_FLAP]  = ps2_key[9];
        9'h01C:  key_d[K_P1_LEFT]  = ps2_key[9];
        9'h01B:  key_d[K_P1_RIGHT] = ps2_key[9];
        9'h175:  key_d[K_P2_FLAP]  = ps2_key[9];
        9'h049:  key_d[K_P2_LEFT]  = ps2_key[9];
        9'h04A:  key_d[K_P2_RIGHT] = ps2_key[9];
        9'h005:  key_d[K_START1]   = ps2_key[9];
        9'h006:  key_d[K_START2]   = ps2_key[9];
        9'h004:  key_d[K_LCOIN]    = ps2_key[9];
        9'h00C:  key_d[K_MCOIN]    = ps2_key[9];
        9'h003:  key_d[K_RCOIN]    = ps2_key[9];
        9'h083:  key_d[K_HSRESET]  = ps2_key[9];
        9'h001:  key_d[K_AUTOUP]   = ps2_key[9];
        9'h009:  key_d[K_ADVANCE]  = ps2_key[9];
        9'h076:  key_d[K_SLAM]     = ps2_key[9];
        default: key_d = key_q;
      endcase
    end else begin
      key_d = key_q;
    end
  end

  // Event detector state and key latches.
  always_ff @(posedge clk_sys or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      tog_q    <= 1'b0;
      primed_q <= 1'b0;
      key_q    <= {NK{1'b0}};
    end else begin
      tog_q    <= ps2_key[10];
      primed_q <= 1'b1;
      key_q    <= key_d;
    end
  end

  assign coin_raw_s[0] = key_q[K_LCOIN];
  assign coin_raw_s[1] = key_q[K_MCOIN] | joy_0[6] | joy_1[6];
  assign coin_raw_s[2] = key_q[K_RCOIN] | joy_0[5] | joy_1[5];

`ifdef JOUST_COIN_SHAPER_EN
  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE    = 2'd1,
    S_GAP      = 2'd2,
    S_WAIT_REL = 2'd3
  } coin_state_e;

  for (genvar g = 0; g < 3; g++) begin : g_coin
    coin_state_e   state_q;
    coin_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          prev_q;
    logic          rise_s;

    assign rise_s        = coin_raw_s[g] & ~prev_q;
    assign coin_out_s[g] = (state_q == S_PULSE);

    // Shaper state, cycle counter and edge reference.
    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
        state_q <= S_IDLE;
        cnt_q   <= {CW{1'b0}};
        prev_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        prev_q  <= coin_raw_s[g];
      end
    end

    // Edges arriving outside IDLE are deliberately dropped: one press, one coin.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        S_IDLE: begin
          if (rise_s) begin
            state_d = S_PULSE;
            cnt_d   = CW'(PULSE_CYC - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PULSE: begin
          if (cnt_q == {CW{1'b0}}) begin
            state_d = S_GAP;
            cnt_d   = CW'(GAP_CYC - 1);
          end else begin
            cnt_d   = cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_q != {CW{1'b0}}) begin
            cnt_d   = cnt_q - CW'(1);
          end else if (coin_raw_s[g]) begin
            state_d = S_WAIT_REL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT_REL: begin
          if (!coin_raw_s[g]) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_REL;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end
  end
`else
  assign coin_out_s = coin_raw_s;
`endif

  assign ja_d = {key_q[K_START1] | joy_0[5], 4'b0000,
                 key_q[K_P1_RIGHT] | joy_0[0], key_q[K_P1_LEFT] | joy_0[1],
                 1'b0, key_q[K_P1_FLAP] | joy_0[4]};
  assign jb_d = {key_q[K_START1] | joy_1[5], 4'b0000,
                 key_q[K_P2_RIGHT] | joy_1[0], key_q[K_P2_LEFT] | joy_1[1],
                 1'b0, key_q[K_P2_FLAP] | joy_1[4]};
  assign sw_d = {key_q[K_START2] | joy_0[6] | joy_1[6], key_q[K_SLAM],
                 coin_out_s[2], coin_out_s[1], coin_out_s[0],
                 key_q[K_HSRESET], key_q[K_ADVANCE], key_q[K_AUTOUP]};

  // Output registers.
  always_ff @(posedge clk_sys or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      sw_q <= 8'h00;
      ja_q <= 9'h000;
      jb_q <= 9'h000;
    end else begin
      sw_q <= sw_d;
      ja_q <= ja_d;
      jb_q <= jb_d;
    end
  end

  assign sw = sw_q;
  assign ja = ja_q;
  assign jb = jb_q;

endmodule
